wr_ptr_ctrl: RTL and testbench

- Write-domain pointer and flag generator for the async FIFO. Parametrised successor of the basic write pointer.
- Holds a binary write pointer with an extra wrap bit and exports a Gray-coded copy for the read domain.
- Synchronises the read-domain Gray pointer, then derives full, almost_full, fill level and a sticky overflow flag.
- Drives the write address and write strobe of the FIFO RAM.

---
 rtl/wr_ptr_ctrl.sv | 119 +++++++++++
 tb/tb_wr_ptr_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wr_ptr_ctrl.sv
// rtl/wr_ptr_ctrl.sv - async FIFO write-domain pointer, synchroniser and flag generator
//
// Keeps a binary write pointer with an extra wrap bit and exports its Gray
// copy for the read domain. Brings the read-domain Gray pointer across with a
// flop chain and derives full, almost_full, fill level and a sticky overflow.
//
// Ports:
//   wclk, wr_srstn      write clock, asynchronous active-low reset
//   wr_en               write request
//   rd_ptr_gray         read pointer (Gray) from the read domain, asynchronous
//   ovf_clr             clears the overflow flag
//   wr_ack, wr_addr     RAM write strobe and address
//   wr_ptr_bin/_gray    registered write pointer, binary and Gray
//   full, almost_full   registered status flags
//   wr_level            registered fill level seen from the write domain
//   overflow            sticky: write attempted while full
module wr_ptr_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  wclk,
  input  logic                  wr_srstn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  input  logic                  ovf_clr,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_bin,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr_bin_q,  wr_ptr_bin_d;
  logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic          full_q,        full_d;
  logic          almost_full_q, almost_full_d;
  logic [PW-1:0] wr_level_q,    wr_level_d;
  logic          overflow_q,    overflow_d;

  logic [PW-1:0] rq_gray;
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] level_next;

  // Acceptance depends only on registered full, so the RAM sees the strobe
  // in the same cycle the request is made.
  assign wr_ack  = wr_en & ~full_q;
  assign wr_addr = wr_ptr_bin_q[ADDR_WIDTH-1:0];

  always_comb begin
    sync_d[0] = rd_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    rq_gray = sync_q[SYNC_STAGES-1];
    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    rq_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rq_bin[i] = ^(rq_gray >> i);
    end
  end

  always_comb begin
    wr_ptr_bin_d  = wr_ptr_bin_q + {{ADDR_WIDTH{1'b0}}, wr_ack};
    wr_ptr_gray_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
    // Level uses the post-write pointer so full rises on the edge of the
    // filling write; the stale read pointer keeps the flags pessimistic.
    level_next    = wr_ptr_bin_d - rq_bin;
    wr_level_d    = level_next;
    full_d        = (level_next == DEPTH_C);
    almost_full_d = (level_next >= AFULL_C);
    // A set in the same cycle as a clear wins.
    overflow_d    = (wr_en & full_q) | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge wclk or negedge wr_srstn) begin
    if (!wr_srstn) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_level_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_level_q    <= wr_level_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_ptr_bin  = wr_ptr_bin_q;
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// tb/tb_wr_ptr_ctrl.sv - self-checking bench for wr_ptr_ctrl
module tb_wr_ptr_ctrl;

  logic       wclk = 1'b0;
  logic       wr_srstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [8:0] rd_ptr_gray = '0;
  logic       ovf_clr = 1'b0;
  logic       wr_ack;
  logic [7:0] wr_addr;
  logic [8:0] wr_ptr_bin;
  logic [8:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [8:0] wr_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] addr_q[$];
  logic [7:0] exp_addr;

  wr_ptr_ctrl #(.ADDR_WIDTH(8), .SYNC_STAGES(2), .AFULL_THRESH(252)) dut (
    .wclk(wclk), .wr_srstn(wr_srstn), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
    .ovf_clr(ovf_clr), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_ptr_bin(wr_ptr_bin),
    .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [8:0] gray(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset;
    repeat (2) @(negedge wclk);
    checks++; if (wr_ptr_bin !== 9'd0) begin errors++; $display("FAIL reset_ptr_bin got %0d exp 0", wr_ptr_bin); end
    checks++; if (wr_ptr_gray !== 9'd0) begin errors++; $display("FAIL reset_ptr_gray got %0h exp 0", wr_ptr_gray); end
    checks++; if ({full, almost_full, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {full, almost_full, overflow}); end
    checks++; if (wr_level !== 9'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", wr_level); end
    wr_srstn = 1'b1;
  endtask

  task automatic test_fill;
    int lvl;
    for (int c = 0; c < 260; c++) begin
      @(negedge wclk);
      lvl = (c < 256) ? c : 256;
      checks++; if (wr_level !== 9'(lvl)) begin errors++; $display("FAIL fill_level c=%0d got %0d exp %0d", c, wr_level, lvl); end
      checks++; if (full !== (c >= 256)) begin errors++; $display("FAIL fill_full c=%0d got %b exp %b", c, full, c >= 256); end
      checks++; if (almost_full !== (lvl >= 252)) begin errors++; $display("FAIL fill_afull c=%0d got %b exp %b", c, almost_full, lvl >= 252); end
      checks++; if (overflow !== (c >= 257)) begin errors++; $display("FAIL fill_ovf c=%0d got %b exp %b", c, overflow, c >= 257); end
      wr_en = 1'b1;
      if (c < 256) addr_q.push_back(c[7:0]);
      #1;
      checks++; if (wr_ack !== (c < 256)) begin errors++; $display("FAIL fill_ack c=%0d got %b exp %b", c, wr_ack, c < 256); end
      if (wr_ack === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++; $display("FAIL fill_addr c=%0d got ack with addr %0d exp no ack", c, wr_addr);
        end else begin
          exp_addr = addr_q.pop_front();
          if (wr_addr !== exp_addr) begin errors++; $display("FAIL fill_addr c=%0d got %0d exp %0d", c, wr_addr, exp_addr); end
        end
      end
    end
    @(negedge wclk);
    wr_en = 1'b0;
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL fill_sb got %0d pending exp 0", addr_q.size()); end
    checks++; if (wr_ptr_bin !== 9'd256) begin errors++; $display("FAIL fill_ptr_bin got %0d exp 256", wr_ptr_bin); end
    checks++; if (wr_ptr_gray !== 9'h180) begin errors++; $display("FAIL fill_ptr_gray got %0h exp 180", wr_ptr_gray); end
    checks++; if (wr_level !== 9'd256) begin errors++; $display("FAIL fill_level_end got %0d exp 256", wr_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf_end got %b exp 1", overflow); end
  endtask

  task automatic test_read_step;
    rd_ptr_gray = 9'h001;
    for (int e = 1; e <= 3; e++) begin
      @(negedge wclk);
      checks++; if (full !== (e < 3)) begin errors++; $display("FAIL step_full edge=%0d got %b exp %b", e, full, e < 3); end
      checks++; if (wr_level !== ((e < 3) ? 9'd256 : 9'd255)) begin errors++; $display("FAIL step_level edge=%0d got %0d", e, wr_level); end
    end
    wr_en = 1'b1;
    addr_q.push_back(8'd0);
    #1;
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL step_ack got %b exp 1", wr_ack); end
    if (wr_ack === 1'b1 && addr_q.size() != 0) begin
      exp_addr = addr_q.pop_front();
      checks++; if (wr_addr !== exp_addr) begin errors++; $display("FAIL step_addr got %0d exp %0d", wr_addr, exp_addr); end
    end
    @(negedge wclk);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL step_refull got %b exp 1", full); end
    checks++; if (wr_ptr_bin !== 9'd257) begin errors++; $display("FAIL step_ptr got %0d exp 257", wr_ptr_bin); end
    #1;
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL step_reject got %b exp 0", wr_ack); end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow;
    @(negedge wclk);
    wr_en = 1'b1; ovf_clr = 1'b1;
    @(negedge wclk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
    checks++; if (wr_ptr_bin !== 9'd257) begin errors++; $display("FAIL ovf_ptr_hold got %0d exp 257", wr_ptr_bin); end
    wr_en = 1'b0;
    @(negedge wclk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    ovf_clr = 1'b0; wr_en = 1'b1;
    @(negedge wclk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_reset got %b exp 1", overflow); end
    wr_en = 1'b0; ovf_clr = 1'b1;
    @(negedge wclk);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %b exp 0", overflow); end
  endtask

  task automatic test_almost_full;
    rd_ptr_gray = gray(9'd5);
    for (int e = 1; e <= 3; e++) begin
      @(negedge wclk);
      checks++; if (wr_level !== ((e < 3) ? 9'd256 : 9'd252)) begin errors++; $display("FAIL af5_level edge=%0d got %0d", e, wr_level); end
    end
    checks++; if ({full, almost_full} !== 2'b01) begin errors++; $display("FAIL af5_flags got %b exp 01", {full, almost_full}); end
    rd_ptr_gray = gray(9'd6);
    for (int e = 1; e <= 3; e++) begin
      @(negedge wclk);
      checks++; if (almost_full !== (e < 3)) begin errors++; $display("FAIL af6_afull edge=%0d got %b exp %b", e, almost_full, e < 3); end
    end
    checks++; if (wr_level !== 9'd251) begin errors++; $display("FAIL af6_level got %0d exp 251", wr_level); end
  endtask

  task automatic test_wrap;
    logic [8:0] prev_gray;
    @(negedge wclk);
    wr_srstn = 1'b0; rd_ptr_gray = '0;
    @(negedge wclk);
    wr_srstn = 1'b1;
    prev_gray = '0;
    for (int k = 0; k < 600; k++) begin
      @(negedge wclk);
      checks++; if (wr_ptr_bin !== k[8:0]) begin errors++; $display("FAIL wrap_ptr k=%0d got %0d exp %0d", k, wr_ptr_bin, k[8:0]); end
      checks++; if (wr_ptr_gray !== gray(k[8:0])) begin errors++; $display("FAIL wrap_gray k=%0d got %0h exp %0h", k, wr_ptr_gray, gray(k[8:0])); end
      if (k > 0) begin
        checks++; if ($countones(wr_ptr_gray ^ prev_gray) != 1) begin errors++; $display("FAIL wrap_hamming k=%0d got %0h from %0h", k, wr_ptr_gray, prev_gray); end
      end
      checks++; if (full !== 1'b0 || wr_level >= 9'd8) begin errors++; $display("FAIL wrap_level k=%0d got level %0d full %b exp <8 and 0", k, wr_level, full); end
      prev_gray = wr_ptr_gray;
      wr_en = 1'b1;
      rd_ptr_gray = gray((k >= 4) ? 9'(k - 4) : 9'd0);
      addr_q.push_back(k[7:0]);
      #1;
      checks++;
      if (wr_ack !== 1'b1 || addr_q.size() == 0) begin
        errors++; $display("FAIL wrap_ack k=%0d got %b exp 1", k, wr_ack);
      end else begin
        exp_addr = addr_q.pop_front();
        if (wr_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr k=%0d got %0d exp %0d", k, wr_addr, exp_addr); end
      end
    end
    @(negedge wclk);
    wr_en = 1'b0;
    checks++; if (wr_ptr_bin !== 9'd88) begin errors++; $display("FAIL wrap_end got %0d exp 88", wr_ptr_bin); end
    addr_q.delete();
  endtask

  task automatic test_reset_mid;
    @(negedge wclk);
    wr_srstn = 1'b0; rd_ptr_gray = '0;
    @(negedge wclk);
    wr_srstn = 1'b1; wr_en = 1'b1;
    repeat (100) @(negedge wclk);
    wr_en = 1'b0;
    checks++; if (wr_level !== 9'd100) begin errors++; $display("FAIL mid_level got %0d exp 100", wr_level); end
    @(posedge wclk);
    #3 wr_srstn = 1'b0;
    #1;
    checks++; if (wr_ptr_bin !== 9'd0 || wr_ptr_gray !== 9'd0) begin errors++; $display("FAIL mid_ptrs got %0d/%0h exp 0", wr_ptr_bin, wr_ptr_gray); end
    checks++; if (wr_level !== 9'd0) begin errors++; $display("FAIL mid_lvl0 got %0d exp 0", wr_level); end
    checks++; if ({full, almost_full, overflow, wr_ack} !== 4'b0000 || wr_addr !== 8'd0) begin errors++; $display("FAIL mid_flags got %b addr %0d exp 0000 addr 0", {full, almost_full, overflow, wr_ack}, wr_addr); end
    @(negedge wclk);
    wr_srstn = 1'b1; wr_en = 1'b1;
    #1;
    checks++; if (wr_ack !== 1'b1 || wr_addr !== 8'd0) begin errors++; $display("FAIL mid_first got ack %b addr %0d exp 1 0", wr_ack, wr_addr); end
    @(negedge wclk);
    wr_en = 1'b0;
    checks++; if (wr_ptr_bin !== 9'd1) begin errors++; $display("FAIL mid_ptr1 got %0d exp 1", wr_ptr_bin); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_step();
    test_overflow();
    test_almost_full();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
